// File: rtl/ex_arith_unit.sv
// Execute-stage arithmetic: a combinational address adder, the ALU control decoder and a
// one-cycle registered ALU. Define EX_ARITH_UNIT_MUL_EN to decode funct 011000 to MUL and build the multiplier.
module ex_arith_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [DATA_W-1:0] add_a_i,
    input  logic [DATA_W-1:0] add_b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic [2:0]        ALUCtrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic              zero_o,
    output logic              valid_o
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [2:0] CTRL_SUB = 3'b110;

    logic [DATA_W-1:0] alu_res;
    logic              vld_pipe;

    assign sum_o = add_a_i + add_b_i;

    always_comb begin
        ALUCtrl_o = CTRL_ADD;
        case (ALUOp_i)
            2'b00: ALUCtrl_o = CTRL_ADD;
            2'b01: ALUCtrl_o = CTRL_SUB;
            2'b11: ALUCtrl_o = CTRL_OR;
            default: begin
                case (funct_i)
                    6'b100000: ALUCtrl_o = CTRL_ADD;
                    6'b100010: ALUCtrl_o = CTRL_SUB;
                    6'b100100: ALUCtrl_o = CTRL_AND;
                    6'b100101: ALUCtrl_o = CTRL_OR;
`ifdef EX_ARITH_UNIT_MUL_EN
                    6'b011000: ALUCtrl_o = CTRL_MUL;
`endif
                    default:   ALUCtrl_o = CTRL_ADD;
                endcase
            end
        endcase
    end

`ifdef EX_ARITH_UNIT_MUL_EN
    logic [DATA_W-1:0] mul_res;
    // Low half of a product is identical for signed and unsigned operands.
    assign mul_res = $signed(data1_i) * $signed(data2_i);
`endif

    always_comb begin
        alu_res = '0;
        case (ALUCtrl_o)
            CTRL_AND: alu_res = data1_i & data2_i;
            CTRL_OR:  alu_res = data1_i | data2_i;
            CTRL_ADD: alu_res = data1_i + data2_i;
            CTRL_SUB: alu_res = data1_i - data2_i;
`ifdef EX_ARITH_UNIT_MUL_EN
            CTRL_MUL: alu_res = mul_res;
`endif
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o   <= '0;
            zero_o   <= 1'b0;
            vld_pipe <= 1'b0;
        end else begin
            vld_pipe <= valid_i;
            if (valid_i) begin
                data_o <= alu_res;
                zero_o <= (alu_res == '0);
            end
        end
    end

    assign valid_o = vld_pipe;

endmodule

// File: tb/tb_ex_arith_unit.sv
// Randomized self-checking bench for ex_arith_unit against a behavioural reference model.
module tb_ex_arith_unit;

    logic        clk_i = 1'b0;
    logic        rst_i, valid_i;
    logic [1:0]  ALUOp_i;
    logic [5:0]  funct_i;
    logic [31:0] data1_i, data2_i, add_a_i, add_b_i;
    logic [31:0] sum_o, data_o;
    logic [2:0]  ALUCtrl_o;
    logic        zero_o, valid_o;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_data;
    logic        exp_zero, exp_valid;

    ex_arith_unit #(.DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUOp_i(ALUOp_i),
        .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
        .add_a_i(add_a_i), .add_b_i(add_b_i), .sum_o(sum_o), .ALUCtrl_o(ALUCtrl_o),
        .data_o(data_o), .zero_o(zero_o), .valid_o(valid_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef EX_ARITH_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Operation name chosen by the instruction, from the decode rules.
    function automatic string op_name(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return "add";
        if (op == 2'd1) return "sub";
        if (op == 2'd3) return "or";
        if (f == 6'd32) return "add";
        if (f == 6'd34) return "sub";
        if (f == 6'd36) return "and";
        if (f == 6'd37) return "or";
        if (f == 6'd24 && MUL_EN) return "mul";
        return "add";
    endfunction

    function automatic logic [2:0] ref_ctrl(input string n);
        case (n)
            "and": return 3'd0;
            "or":  return 3'd1;
            "mul": return 3'd3;
            "sub": return 3'd6;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input string n, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (n)
            "and": return a & b;
            "or":  return a | b;
            "sub": return 32'((sa - sb) % 64'sh1_0000_0000);
            "mul": begin p = sa * sb; return p[31:0]; end
            default: return 32'((sa + sb) % 64'sh1_0000_0000);
        endcase
    endfunction

    task automatic step(input logic rst, input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] aa, input logic [31:0] ab);
        string n;
        longint s;
        rst_i = rst; valid_i = v; ALUOp_i = op; funct_i = f;
        data1_i = a; data2_i = b; add_a_i = aa; add_b_i = ab;
        #1;
        n = op_name(op, f);
        s = longint'(aa) + longint'(ab);
        check("alu_ctrl", {29'd0, ALUCtrl_o}, {29'd0, ref_ctrl(n)});
        check("sum", sum_o, s[31:0]);
        if (rst) begin
            exp_data = 0; exp_zero = 0; exp_valid = 0;
        end else begin
            exp_valid = v;
            if (v) begin
                exp_data = ref_alu(n, a, b);
                exp_zero = (exp_data == 0);
            end
        end
        @(posedge clk_i); #1;
        check("data", data_o, exp_data);
        check("zero", {31'd0, zero_o}, {31'd0, exp_zero});
        check("valid", {31'd0, valid_o}, {31'd0, exp_valid});
    endtask

    initial begin
        logic [5:0] fl [6];
        fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37; fl[4] = 6'd24; fl[5] = 6'd0;
        exp_data = 0; exp_zero = 0; exp_valid = 0;
        @(negedge clk_i);
        // reset state
        step(1, 0, 2'b00, 6'd0, 0, 0, 0, 0);
        step(1, 0, 2'b00, 6'd0, 0, 0, 0, 0);
        check("rst_data", data_o, 32'd0);
        // adder
        step(0, 0, 2'b00, 6'd0, 0, 0, 32'h100, 32'd4);
        check("pc4", sum_o, 32'h104);
        step(0, 0, 2'b00, 6'd0, 0, 0, 32'hFFFF_FFFC, 32'd4);
        // R-type SUB to zero
        step(0, 1, 2'b10, 6'b100010, 5, 5, 0, 0);
        check("sub_zero", {31'd0, zero_o}, 32'd1);
        // ALUOp classes
        step(0, 1, 2'b00, 6'd0, 32'h10, 32'hFFFF_FFFC, 0, 0);
        check("lw_add", data_o, 32'h0C);
        step(0, 1, 2'b01, 6'd0, 32'h10, 32'h10, 0, 0);
        step(0, 1, 2'b11, 6'd0, 32'hF0, 32'h0F, 0, 0);
        check("ori", data_o, 32'hFF);
        step(0, 1, 2'b10, 6'b100100, 32'hF0, 32'h3C, 0, 0);
        check("and", data_o, 32'h30);
        // MUL / fallback ADD
        step(0, 1, 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("mul", data_o, MUL_EN ? 32'hFFFF_FFEB : 32'd4);
        // wrap boundaries
        step(0, 1, 2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, 0, 0);
        check("wrap_add", data_o, 32'h8000_0000);
        step(0, 1, 2'b01, 6'd0, 32'd0, 32'd1, 0, 0);
        check("wrap_sub", data_o, 32'hFFFF_FFFF);
        // reset overrides valid
        step(1, 1, 2'b00, 6'd0, 32'd1, 32'd2, 0, 0);
        check("rst_ovr", {31'd0, valid_o}, 32'd0);
        // bubble 1,0,1
        step(0, 1, 2'b00, 6'd0, 32'd9, 32'd1, 0, 0);
        step(0, 0, 2'b00, 6'd0, 32'd3, 32'd3, 0, 0);
        check("bubble_hold", data_o, 32'd10);
        step(0, 1, 2'b10, 6'b100101, 32'h5, 32'hA, 0, 0);
        // random
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 6'($urandom) : fl[$urandom_range(0, 5)],
                 ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                 $urandom, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
